// File: rtl/kernel_kcore_wb_pkg.sv
// Shared types and helpers for the k-core write-back stage.
package kernel_kcore_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_e;

    // Widest update word the slice helpers accept ({vid, core}).
    localparam int UPD_MAX_W = 128;

    function automatic int addr_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic logic [63:0] upd_vid(input logic [UPD_MAX_W-1:0] word,
                                            input int data_width);
        return 64'(word >> data_width);
    endfunction

    function automatic logic [63:0] upd_core(input logic [UPD_MAX_W-1:0] word,
                                             input int data_width);
        logic [UPD_MAX_W-1:0] mask;
        mask = (UPD_MAX_W'(1) << data_width) - UPD_MAX_W'(1);
        return 64'(word & mask);
    endfunction

endpackage

// File: rtl/kernel_kcore_wb_out_reg.sv
// Single-entry valid/ready holding register for one write request (address + data).
module kernel_kcore_wb_out_reg
    import kernel_kcore_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  accept,
    output logic                  empty
);

    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    assign accept    = valid_q & out_ready;
    assign empty     = ~valid_q;
    assign out_valid = valid_q;
    assign out_addr  = addr_q;
    assign out_data  = data_q;

    // A load wins over an accept so a pop can refill the slot in the handshake cycle.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            addr_d  = load_addr;
            data_d  = load_data;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/kernel_kcore_write_back.sv
// K-core write-back stage: drains (vid, core) updates into single-beat memory
// writes with a bounded number of outstanding responses, then pulses done.
module kernel_kcore_write_back
    import kernel_kcore_wb_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int VID_WIDTH       = 32,
    parameter int ADDR_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start_empty_n,
    output logic                          start_read,
    input  logic [ADDR_WIDTH-1:0]         cfg_base,
    input  logic [31:0]                   cfg_num,
    input  logic                          upd_empty_n,
    output logic                          upd_read,
    input  logic [VID_WIDTH+DATA_WIDTH-1:0] upd_dout,
    output logic                          mem_awvalid,
    input  logic                          mem_awready,
    output logic [ADDR_WIDTH-1:0]         mem_awaddr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic                          mem_bvalid,
    output logic                          mem_bready,
    output logic                          ap_idle,
    output logic                          ap_done
);

    localparam int ADDR_SHIFT = addr_shift(DATA_WIDTH);
    localparam int OUT_W      = $clog2(MAX_OUTSTANDING) + 1;

    wb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           num_q, num_d;
    logic [31:0]           popped_q, popped_d;
    logic [31:0]           issued_q, issued_d;
    logic [31:0]           resp_q, resp_d;
    logic [OUT_W-1:0]      outstanding_q, outstanding_d;

    logic [UPD_MAX_W-1:0]  upd_word;
    logic [VID_WIDTH-1:0]  vid;
    logic [DATA_WIDTH-1:0] core;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic                  aw_hs;
    logic                  b_hs;
    logic                  out_empty;
    logic [OUT_W-1:0]      outstanding_next;
    logic [31:0]           resp_next;

    assign upd_word  = UPD_MAX_W'(upd_dout);
    assign vid       = VID_WIDTH'(upd_vid(upd_word, DATA_WIDTH));
    assign core      = DATA_WIDTH'(upd_core(upd_word, DATA_WIDTH));
    assign load_addr = base_q + (ADDR_WIDTH'(vid) << ADDR_SHIFT);

    // Responses with nothing outstanding are stray (e.g. after an abort) and dropped.
    assign b_hs       = mem_bvalid & (outstanding_q != '0);
    assign mem_bready = 1'b1;
    assign ap_idle    = (state_q == ST_IDLE);
    assign ap_done    = (state_q == ST_DONE);

    kernel_kcore_wb_out_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (upd_read),
        .load_addr (load_addr),
        .load_data (core),
        .out_ready (mem_awready),
        .out_valid (mem_awvalid),
        .out_addr  (mem_awaddr),
        .out_data  (mem_wdata),
        .accept    (aw_hs),
        .empty     (out_empty)
    );

    always_comb begin
        outstanding_next = outstanding_q;
        if (aw_hs && !b_hs) begin
            outstanding_next = outstanding_q + OUT_W'(1);
        end else if (!aw_hs && b_hs) begin
            outstanding_next = outstanding_q - OUT_W'(1);
        end
        resp_next = b_hs ? resp_q + 32'd1 : resp_q;
    end

    // The pop limit uses the post-cycle outstanding count so a freed slot is reusable at once.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        num_d         = num_q;
        popped_d      = popped_q;
        issued_d      = aw_hs ? issued_q + 32'd1 : issued_q;
        resp_d        = resp_next;
        outstanding_d = outstanding_next;
        start_read    = 1'b0;
        upd_read      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_empty_n && reset_n) begin
                    start_read    = 1'b1;
                    base_d        = cfg_base;
                    num_d         = cfg_num;
                    popped_d      = '0;
                    issued_d      = '0;
                    resp_d        = '0;
                    outstanding_d = '0;
                    state_d       = (cfg_num == 32'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                upd_read = upd_empty_n && (popped_q < num_q) &&
                           (outstanding_next < OUT_W'(MAX_OUTSTANDING)) &&
                           (out_empty || aw_hs);
                if (upd_read) begin
                    popped_d = popped_q + 32'd1;
                end
                if ((issued_q == num_q) && out_empty) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (resp_next == num_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            num_q         <= '0;
            popped_q      <= '0;
            issued_q      <= '0;
            resp_q        <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            num_q         <= num_d;
            popped_q      <= popped_d;
            issued_q      <= issued_d;
            resp_q        <= resp_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: tb/tb_kernel_kcore_write_back.sv
// Directed self-checking bench for kernel_kcore_write_back (MAX_OUTSTANDING=4).
module tb_kernel_kcore_write_back;

    localparam int DW = 32;
    localparam int VW = 32;
    localparam int AW = 64;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start_empty_n;
    logic          start_read;
    logic [AW-1:0] cfg_base;
    logic [31:0]   cfg_num;
    logic          upd_empty_n;
    logic          upd_read;
    logic [VW+DW-1:0] upd_dout;
    logic          mem_awvalid;
    logic          mem_awready;
    logic [AW-1:0] mem_awaddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_bvalid;
    logic          mem_bready;
    logic          ap_idle;
    logic          ap_done;

    always #5 clk = ~clk;

    kernel_kcore_write_back #(
        .DATA_WIDTH      (DW),
        .VID_WIDTH       (VW),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_empty_n (start_empty_n),
        .start_read    (start_read),
        .cfg_base      (cfg_base),
        .cfg_num       (cfg_num),
        .upd_empty_n   (upd_empty_n),
        .upd_read      (upd_read),
        .upd_dout      (upd_dout),
        .mem_awvalid   (mem_awvalid),
        .mem_awready   (mem_awready),
        .mem_awaddr    (mem_awaddr),
        .mem_wdata     (mem_wdata),
        .mem_bvalid    (mem_bvalid),
        .mem_bready    (mem_bready),
        .ap_idle       (ap_idle),
        .ap_done       (ap_done)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [63:0] vq[$];
    int          b_due[$];
    logic [63:0] aw_addr_log[$];
    logic [63:0] aw_data_log[$];

    int   tokens = 0;
    bit   rnd_ready = 0;
    bit   b_hold = 0;
    bit   stray_b = 0;
    int   start_pulses = 0;
    int   upd_reads = 0;
    int   aw_cycles = 0;
    int   model_out = 0;
    int   max_out = 0;
    int   b_count = 0;
    int   done_count = 0;
    int   done_cyc = -10;
    int   start_cyc = -10;
    int   last_b_cyc = -10;
    int   stab_viol = 0;
    int   drop_viol = 0;
    bit   prev_stall = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    bit   idle_after_done = 0;
    bit   last_awvalid = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Environment: drive FIFO/memory inputs at negedge, then sample the settled outputs.
    always @(negedge clk) begin
        cyc++;
        upd_empty_n   = (vq.size() != 0);
        upd_dout      = (vq.size() != 0) ? vq[0] : '0;
        start_empty_n = (tokens > 0);
        mem_awready   = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_bvalid    = stray_b || (!b_hold && b_due.size() > 0 && b_due[0] <= cyc);
        #1;
        if (reset_n) begin
            if (cyc == done_cyc + 1) idle_after_done = ap_idle;
            if (start_read) begin
                tokens--;
                start_pulses++;
                start_cyc = cyc;
            end
            if (upd_read) begin
                void'(vq.pop_front());
                upd_reads++;
            end
            if (mem_awvalid) begin
                aw_cycles++;
                if (prev_stall && (mem_awaddr !== prev_addr || mem_wdata !== prev_data)) stab_viol++;
            end else if (prev_stall) begin
                drop_viol++;
            end
            prev_stall   = mem_awvalid && !mem_awready;
            prev_addr    = mem_awaddr;
            prev_data    = mem_wdata;
            last_awvalid = mem_awvalid;
            if (mem_bvalid && mem_bready && !stray_b && b_due.size() > 0) begin
                void'(b_due.pop_front());
                model_out--;
                b_count++;
                last_b_cyc = cyc;
            end
            if (mem_awvalid && mem_awready) begin
                aw_addr_log.push_back(64'(mem_awaddr));
                aw_data_log.push_back(64'(mem_wdata));
                b_due.push_back(cyc + 2);
                model_out++;
                if (model_out > max_out) max_out = model_out;
            end
            if (ap_done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic push_upd(input logic [31:0] vid, input logic [31:0] core);
        vq.push_back({vid, core});
    endtask

    task automatic applyStimulus(input logic [63:0] base, input int num);
        @(posedge clk);
        #2;
        cfg_base = base;
        cfg_num  = 32'(num);
        tokens++;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int n = 0;
        while (done_count == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_count == d0) checkOutput(tag, 64'd0, 64'd1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_idle"}, 64'(ap_idle), 64'd1);
        checkOutput({tag, "_done"}, 64'(ap_done), 64'd0);
        checkOutput({tag, "_start_read"}, 64'(start_read), 64'd0);
        checkOutput({tag, "_upd_read"}, 64'(upd_read), 64'd0);
        checkOutput({tag, "_awvalid"}, 64'(mem_awvalid), 64'd0);
        checkOutput({tag, "_bready"}, 64'(mem_bready), 64'd1);
    endtask

    initial begin
        logic [63:0] t1_addr[3];
        logic [63:0] t1_data[3];
        int d0;
        int base_aw;
        int s0;
        int ur0;
        int awc0;
        int b0;
        int n;

        t1_addr = '{64'h1014, 64'h1000, 64'h1024};
        t1_data = '{64'd7, 64'd1, 64'd2};

        reset_n = 1'b0;
        start_empty_n = 1'b0;
        upd_empty_n = 1'b0;
        upd_dout = '0;
        cfg_base = '0;
        cfg_num = '0;
        mem_awready = 1'b1;
        mem_bvalid = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Basic run: three updates plus one extra word that must stay queued.
        push_upd(32'd5, 32'd7);
        push_upd(32'd0, 32'd1);
        push_upd(32'd9, 32'd2);
        push_upd(32'd4, 32'd4);
        base_aw = aw_addr_log.size();
        d0 = done_count;
        applyStimulus(64'h1000, 3);
        wait_done(d0, 200, "t1_timeout");
        checkOutput("t1_aw_count", 64'(aw_addr_log.size() - base_aw), 64'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t1_awaddr%0d", i), aw_addr_log[base_aw + i], t1_addr[i]);
            checkOutput($sformatf("t1_wdata%0d", i), aw_data_log[base_aw + i], t1_data[i]);
        end
        checkOutput("t1_done_pulses", 64'(done_count - d0), 64'd1);
        checkOutput("t1_done_after_b", 64'(done_cyc - last_b_cyc), 64'd1);
        checkOutput("t1_idle_after_done", 64'(idle_after_done), 64'd1);
        checkOutput("t1_extra_left", 64'(vq.size()), 64'd1);
        vq.delete();

        // Empty run: start pop then done the next cycle, no traffic.
        d0 = done_count;
        s0 = start_pulses;
        ur0 = upd_reads;
        awc0 = aw_cycles;
        applyStimulus(64'h500, 0);
        wait_done(d0, 50, "t2_timeout");
        checkOutput("t2_start_pulses", 64'(start_pulses - s0), 64'd1);
        checkOutput("t2_done_latency", 64'(done_cyc - start_cyc), 64'd1);
        checkOutput("t2_done_pulses", 64'(done_count - d0), 64'd1);
        checkOutput("t2_upd_reads", 64'(upd_reads - ur0), 64'd0);
        checkOutput("t2_awvalid_cycles", 64'(aw_cycles - awc0), 64'd0);

        // Outstanding limit: responses withheld, issue must stall at MO.
        for (int i = 0; i < 10; i++) push_upd(32'(i + 10), 32'(i * 3 + 1));
        b_hold = 1;
        max_out = model_out;
        base_aw = aw_addr_log.size();
        ur0 = upd_reads;
        b0 = b_count;
        d0 = done_count;
        applyStimulus(64'h8000, 10);
        repeat (20) @(posedge clk);
        #2;
        checkOutput("t3_stall_aw_count", 64'(aw_addr_log.size() - base_aw), 64'd4);
        checkOutput("t3_stall_awvalid", 64'(last_awvalid), 64'd0);
        checkOutput("t3_stall_upd_reads", 64'(upd_reads - ur0), 64'd4);
        b_hold = 0;
        wait_done(d0, 300, "t3_timeout");
        checkOutput("t3_aw_count", 64'(aw_addr_log.size() - base_aw), 64'd10);
        checkOutput("t3_b_count", 64'(b_count - b0), 64'd10);
        checkOutput("t3_max_outstanding", 64'(max_out), 64'd4);
        checkOutput("t3_done_pulses", 64'(done_count - d0), 64'd1);
        for (int i = 0; i < 10; i++) begin
            if (base_aw + i < aw_addr_log.size()) begin
                checkOutput($sformatf("t3_awaddr%0d", i), aw_addr_log[base_aw + i], 64'h8000 + 64'((i + 10) * 4));
                checkOutput($sformatf("t3_wdata%0d", i), aw_data_log[base_aw + i], 64'(i * 3 + 1));
            end
        end

        // Backpressure on the address channel.
        for (int i = 0; i < 8; i++) push_upd(32'(7 - i), 32'(32'hA0 + i));
        rnd_ready = 1;
        stab_viol = 0;
        drop_viol = 0;
        base_aw = aw_addr_log.size();
        d0 = done_count;
        applyStimulus(64'h40, 8);
        wait_done(d0, 400, "t4_timeout");
        rnd_ready = 0;
        checkOutput("t4_stable_violations", 64'(stab_viol), 64'd0);
        checkOutput("t4_drop_violations", 64'(drop_viol), 64'd0);
        checkOutput("t4_aw_count", 64'(aw_addr_log.size() - base_aw), 64'd8);
        checkOutput("t4_fifo_left", 64'(vq.size()), 64'd0);
        for (int i = 0; i < 8; i++) begin
            if (base_aw + i < aw_addr_log.size()) begin
                checkOutput($sformatf("t4_awaddr%0d", i), aw_addr_log[base_aw + i], 64'h40 + 64'((7 - i) * 4));
                checkOutput($sformatf("t4_wdata%0d", i), aw_data_log[base_aw + i], 64'(32'hA0 + i));
            end
        end

        // Address wrap-around.
        push_upd(32'd3, 32'hAB);
        base_aw = aw_addr_log.size();
        d0 = done_count;
        applyStimulus(64'hFFFF_FFFF_FFFF_FFF8, 1);
        wait_done(d0, 100, "t5_timeout");
        checkOutput("t5_aw_count", 64'(aw_addr_log.size() - base_aw), 64'd1);
        if (aw_addr_log.size() > base_aw) begin
            checkOutput("t5_awaddr_wrap", aw_addr_log[base_aw], 64'h4);
            checkOutput("t5_wdata", aw_data_log[base_aw], 64'hAB);
        end

        // Abort mid-run, stray response, then a clean restart.
        for (int i = 0; i < 5; i++) push_upd(32'(20 + i), 32'(i));
        base_aw = aw_addr_log.size();
        applyStimulus(64'h3000, 5);
        n = 0;
        while (aw_addr_log.size() < base_aw + 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (aw_addr_log.size() < base_aw + 2) checkOutput("t6_wait_timeout", 64'd0, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t6_abort");
        vq.delete();
        b_due.delete();
        model_out = 0;
        prev_stall = 0;
        tokens = 0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        stray_b = 1;
        @(posedge clk);
        #2;
        stray_b = 0;
        push_upd(32'd1, 32'd11);
        push_upd(32'd2, 32'd22);
        base_aw = aw_addr_log.size();
        d0 = done_count;
        applyStimulus(64'h2000, 2);
        wait_done(d0, 100, "t6_timeout");
        checkOutput("t6_aw_count", 64'(aw_addr_log.size() - base_aw), 64'd2);
        checkOutput("t6_done_pulses", 64'(done_count - d0), 64'd1);
        if (aw_addr_log.size() >= base_aw + 2) begin
            checkOutput("t6_awaddr0", aw_addr_log[base_aw], 64'h2004);
            checkOutput("t6_awaddr1", aw_addr_log[base_aw + 1], 64'h2008);
            checkOutput("t6_wdata1", aw_data_log[base_aw + 1], 64'd22);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
